// File: rtl/multdiv_seq.sv
// Iterative 32-bit signed multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional build macro MULTDIV_DIV0_FAST_EN: divide-by-zero completes one cycle after start.
module multdiv_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] i_insn,
   input  logic [31:0] i_operandA,
   input  logic [31:0] i_operandB,
   input  logic        i_ctrl_MULT,
   input  logic        i_ctrl_DIV,
   output logic [31:0] o_insn,
   output logic [31:0] o_result,
   output logic        o_exception,
   output logic        o_MD_rdy,
   output logic        o_busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic        op_div;
   logic        neg;
   logic        b_zero;
   logic [63:0] mcand;
   logic [63:0] acc;
   logic [31:0] mplier;
   logic [31:0] dvd;
   logic [31:0] dvsr;
   logic [31:0] rem;
`ifdef MULTDIV_DIV0_FAST_EN
   logic        div0_pend;
`endif

   logic        start;
   logic        start_div;
   logic [31:0] a_mag;
   logic [31:0] b_mag;

   logic [63:0] acc_nxt;
   logic [32:0] rem_sh;
   logic [32:0] rem_diff;
   logic        q_bit;
   logic [31:0] quo;
   logic [63:0] prod;
   logic        mul_exc;
   logic [31:0] quo_s;
   logic [31:0] fin_result;
   logic        fin_exc;

   assign start     = i_ctrl_MULT | i_ctrl_DIV;
   assign start_div = i_ctrl_DIV & ~i_ctrl_MULT;
   assign a_mag     = i_operandA[31] ? (~i_operandA + 32'd1) : i_operandA;
   assign b_mag     = i_operandB[31] ? (~i_operandB + 32'd1) : i_operandB;
   assign o_busy    = (state == RUN);

   // Datapath for one iteration plus the sign fix-up applied on the final edge.
   always_comb begin
      acc_nxt  = acc + (mplier[0] ? mcand : '0);
      rem_sh   = {rem, dvd[31]};
      rem_diff = rem_sh - {1'b0, dvsr};
      q_bit    = ~rem_diff[32];
      quo      = {dvd[30:0], q_bit};
      prod     = neg ? (~acc_nxt + 64'd1) : acc_nxt;
      mul_exc  = ~((&prod[63:31]) | ~(|prod[63:31]));
      quo_s    = neg ? (~quo + 32'd1) : quo;
      if (op_div) begin
         fin_result = b_zero ? '0 : quo_s;
         fin_exc    = b_zero | (~neg & quo[31]);
      end else begin
         fin_result = prod[31:0];
         fin_exc    = mul_exc;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         op_div      <= 1'b0;
         neg         <= 1'b0;
         b_zero      <= 1'b0;
         mcand       <= '0;
         acc         <= '0;
         mplier      <= '0;
         dvd         <= '0;
         dvsr        <= '0;
         rem         <= '0;
         o_insn      <= '0;
         o_result    <= '0;
         o_exception <= 1'b0;
         o_MD_rdy    <= 1'b0;
`ifdef MULTDIV_DIV0_FAST_EN
         div0_pend   <= 1'b0;
`endif
      end else if (start) begin
         // A start always wins, aborting any operation in flight.
         state    <= RUN;
         cnt      <= '0;
         op_div   <= start_div;
         neg      <= i_operandA[31] ^ i_operandB[31];
         b_zero   <= (i_operandB == '0);
         mcand    <= {32'd0, a_mag};
         acc      <= '0;
         mplier   <= b_mag;
         dvd      <= a_mag;
         dvsr     <= b_mag;
         rem      <= '0;
         o_insn   <= i_insn;
         o_MD_rdy <= 1'b0;
`ifdef MULTDIV_DIV0_FAST_EN
         div0_pend <= 1'b0;
         if (start_div && (i_operandB == '0)) begin
            state     <= IDLE;
            div0_pend <= 1'b1;
         end
`endif
      end else begin
         case (state)
            IDLE: begin
               o_MD_rdy <= 1'b0;
`ifdef MULTDIV_DIV0_FAST_EN
               if (div0_pend) begin
                  state       <= DONE;
                  div0_pend   <= 1'b0;
                  o_MD_rdy    <= 1'b1;
                  o_result    <= '0;
                  o_exception <= 1'b1;
               end
`endif
            end
            RUN: begin
               if (op_div) begin
                  rem <= q_bit ? rem_diff[31:0] : rem_sh[31:0];
                  dvd <= quo;
               end else begin
                  acc    <= acc_nxt;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) begin
                  state       <= DONE;
                  o_MD_rdy    <= 1'b1;
                  o_result    <= fin_result;
                  o_exception <= fin_exc;
               end
            end
            DONE: begin
               state    <= IDLE;
               o_MD_rdy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               o_MD_rdy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Iterative 32-bit signed multiply/divide unit occupying the P stage of the pipeline, directly upstream of the P/W latch. It accepts a one-cycle start pulse with two operands and the owning instruction word, iterates one bit per clock, then presents the result, exception flag, instruction word and a one-cycle ready pulse. These outputs feed the P/W latch inputs `i_result`, `i_insn` and `i_MD_rdy` directly.

## Interface
Parameters: none (width fixed at 32).
- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `i_insn`  in  32  instruction word of the issuing mult/div
- `i_operandA`  in  32  multiplicand / dividend (two's complement)
- `i_operandB`  in  32  multiplier / divisor (two's complement)
- `i_ctrl_MULT`  in  1  start-multiply pulse
- `i_ctrl_DIV`  in  1  start-divide pulse
- `o_insn`  out  32  captured instruction word of current/last operation
- `o_result`  out  32  low 32 bits of product, or quotient
- `o_exception`  out  1  overflow or divide-by-zero for the completed op
- `o_MD_rdy`  out  1  one-cycle completion pulse
- `o_busy`  out  1  high while an operation is in flight (RUN state)

## Operation
- States: IDLE, RUN, DONE. Reset (reset=0) forces IDLE, 6-bit counter=0, and all outputs 0 asynchronously.
- Start: a rising edge with `i_ctrl_MULT` or `i_ctrl_DIV` high captures operands, `i_insn` and op type, sets counter=0, and enters RUN. This applies from any state.
- Both ctrl high on the same edge: multiply is performed.
- Start while RUN or DONE aborts the current operation. No `o_MD_rdy` is produced for the aborted op.
- Operands are converted to magnitudes; result sign is fixed at completion (sign A XOR sign B).
- Multiply: radix-2 shift-add on magnitudes, 64-bit accumulator, one bit per cycle. `o_result` = low 32 bits of the signed product. `o_exception`=1 iff the signed 64-bit product is outside [-2^31, 2^31-1].
- Divide: restoring, one quotient bit per cycle, truncating toward zero; remainder discarded.
  - Divisor 0: `o_result`=0, `o_exception`=1.
  - 0x80000000 / -1: `o_result`=0x80000000, `o_exception`=1.
- RUN performs 32 iterations (counter 0..31). The edge performing iteration 31 moves to DONE and updates `o_result`/`o_exception`.
- DONE lasts one cycle with `o_MD_rdy`=1, then returns to IDLE.
- `o_result`, `o_exception` and `o_insn` hold their values until the next completion or reset. `o_insn` updates at start.
- `o_busy`=1 exactly while in RUN.

## Timing
- Start sampled on edge E0. Iterations occur on edges E1..E32. `o_MD_rdy` is high from E32 to E33.
- Latency is 32 cycles; throughput is one op per 33 cycles (a new start may be issued on E33, or earlier by abort).
- Outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-RUN clears state immediately. No `o_MD_rdy` follows.
- Reset release: the first rising edge with reset=1 may sample a start.

## Configuration
- `MULTDIV_DIV0_FAST_EN` defined: a divide with divisor 0 enters DONE on E1 (`o_MD_rdy` high E1–E2, `o_result`=0, `o_exception`=1). `o_busy` stays 0.
- Undefined: divide-by-zero runs the full 32 iterations and completes at E32 like any other op.
- Multiply timing is identical in both builds.

## Test plan
- MULT A=7, B=-3 (0xFFFFFFFD), `i_insn`=0x12345678 -> at E32 `o_MD_rdy`=1 for exactly one cycle, `o_result`=0xFFFFFFEB, `o_exception`=0, `o_insn`=0x12345678.
- MULT A=0x00010000, B=0x00010000 -> `o_result`=0x00000000, `o_exception`=1. MULT A=-1, B=0x80000000 -> `o_result`=0x80000000, `o_exception`=1.
- DIV A=-7, B=2 -> `o_result`=0xFFFFFFFD (-3), `o_exception`=0. DIV A=0x80000000, B=-1 -> `o_result`=0x80000000, `o_exception`=1.
- DIV A=5, B=0 -> `o_result`=0, `o_exception`=1. Completion at E32 without the macro, at E1 with `MULTDIV_DIV0_FAST_EN`.
- MULT 3×4 started, then DIV 100/7 started at E10 -> no rdy for the mult. Single rdy 32 cycles after E10 with `o_result`=14. Simultaneous MULT+DIV ctrl -> product returned.
- Reset asserted at E15 of a MULT -> all outputs 0 immediately. No `o_MD_rdy` in the following 40 cycles.
